fminmax_pipe: RTL and testbench

- Two-stage pipelined IEEE-754 single-precision min/max unit with valid/ready handshakes on both sides.
- Uses the same sign/exponent/mantissa ordering as the FPU's less-than comparator, but returns the selected operand instead of a flag.
- Adds full NaN and signed-zero handling.
- Sits in the FPU beside the comparator and serves FMIN/FMAX instructions.

---
 rtl/fminmax_pipe.sv | 134 +++++++++++++
 tb/tb_fminmax_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fminmax_pipe.sv
// fminmax_pipe: two-stage IEEE-754 single-precision FMIN/FMAX unit.
// Latency 2 cycles from input handshake to out_valid; throughput 1/cycle.
// Backpressure: stages advance only when downstream has room; in_ready is
// combinational from out_ready and pipeline state only.
module fminmax_pipe #(
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        invalid,
  output logic        out_valid,
  input  logic        out_ready
);

  // NaN: all-ones exponent with a non-zero mantissa.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Signaling NaN: NaN with the quiet bit clear.
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  // Ordered less-than for non-NaN operands; -0 sorts below +0 and
  // denormals are compared by raw magnitude bits.
  function automatic logic ord_lt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if (a[31] != b[31]) begin
      res = a[31];
    end else if (!a[31]) begin
      res = a[30:0] < b[30:0];
    end else begin
      res = a[30:0] > b[30:0];
    end
    return res;
  endfunction

  // Stage 1 state
  logic        s1_valid_q;
  logic [31:0] s1_op1_q, s1_op2_q;
  logic        s1_mode_q;
  logic        s1_nan1_q, s1_nan2_q;
  logic        s1_snan1_q, s1_snan2_q;
  logic        s1_lt_q;

  // Stage 2 state (drives the outputs directly)
  logic        out_valid_q;
  logic [31:0] result_q;
  logic        invalid_q;

  // Stage 2 next-state values
  logic [31:0] result_d;
  logic        invalid_d;

  logic        s2_ready;

  // Stage 2 can take new data when empty or when its item leaves this cycle;
  // stage 1 can accept when empty or when it moves into stage 2.
  always_comb begin
    s2_ready = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_ready;
  end

  // Final selection from the stage-1 classification and ordering bits.
  always_comb begin
    result_d  = 32'h0;
    invalid_d = s1_snan1_q || s1_snan2_q;
    if (s1_nan1_q && s1_nan2_q) begin
      result_d = CANON_NAN;
    end else if (s1_nan1_q) begin
      result_d = s1_op2_q;
    end else if (s1_nan2_q) begin
      result_d = s1_op1_q;
    end else if (s1_mode_q) begin
      result_d = s1_lt_q ? s1_op2_q : s1_op1_q;
    end else begin
      result_d = s1_lt_q ? s1_op1_q : s1_op2_q;
    end
  end

  // Stage 1: capture operands and their classification on input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op1_q   <= 32'h0;
      s1_op2_q   <= 32'h0;
      s1_mode_q  <= 1'b0;
      s1_nan1_q  <= 1'b0;
      s1_nan2_q  <= 1'b0;
      s1_snan1_q <= 1'b0;
      s1_snan2_q <= 1'b0;
      s1_lt_q    <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op1_q   <= op1;
        s1_op2_q   <= op2;
        s1_mode_q  <= mode;
        s1_nan1_q  <= is_nan(op1);
        s1_nan2_q  <= is_nan(op2);
        s1_snan1_q <= is_snan(op1);
        s1_snan2_q <= is_snan(op2);
        s1_lt_q    <= ord_lt(op1, op2);
      end
    end
  end

  // Stage 2: register the selected result; hold it while the output stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      invalid_q   <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q  <= result_d;
        invalid_q <= invalid_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fminmax_pipe.sv
module tb_fminmax_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        invalid;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fminmax_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .op1       (op1),
    .op2       (op2),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .invalid   (invalid),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- reference model ----------------
  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit m_snan(input logic [31:0] x);
    return m_nan(x) && (x[22] == 1'b0);
  endfunction

  // Map a non-NaN float to a signed integer on the number line; -0 maps
  // just below +0 so signed zeros order strictly.
  function automatic longint m_key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? (-mag - 1) : mag;
  endfunction

  // Returns {invalid, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic m);
    logic [31:0] r;
    bit inv;
    inv = m_snan(a) || m_snan(b);
    if (m_nan(a) && m_nan(b))      r = 32'h7FC00000;
    else if (m_nan(a))             r = b;
    else if (m_nan(b))             r = a;
    else if (m == 1'b0)            r = (m_key(a) <= m_key(b)) ? a : b;
    else                           r = (m_key(a) >= m_key(b)) ? a : b;
    return {inv, r};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] x;
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       x = $urandom;
      1:       x = {s, 8'hFF, 23'd0};
      2:       x = {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      3:       x = {s, 31'd0};
      4:       x = {s, 8'hFF, 1'b1, 22'($urandom)};
      5:       x = {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
      default: x = {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op and wait for its result with out_ready held high.
  // lat counts clock edges from the accepting edge to out_valid.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                       output logic [31:0] r, output logic inv, output int lat);
    int n;
    n = 0;
    op1 = a; op2 = b; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = result;
    inv = invalid;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; mode = 1'b0;
    tick(); tick();
    tests++;
    if (out_valid !== 1'b0 || result !== 32'h0 || invalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b result=%h invalid=%b, want 0/00000000/0", out_valid, result, invalid);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ta[5], tb_[5], te[5];
    logic        tm[5];
    logic [31:0] r;
    logic        inv;
    int          lat;
    ta[0] = 32'h3F800000; tb_[0] = 32'h40000000; tm[0] = 0; te[0] = 32'h3F800000;
    ta[1] = 32'hC0000000; tb_[1] = 32'hBF800000; tm[1] = 1; te[1] = 32'hBF800000;
    ta[2] = 32'h00000000; tb_[2] = 32'h80000000; tm[2] = 0; te[2] = 32'h80000000;
    ta[3] = 32'h00000000; tb_[3] = 32'h80000000; tm[3] = 1; te[3] = 32'h00000000;
    ta[4] = 32'h80000000; tb_[4] = 32'h80000000; tm[4] = 0; te[4] = 32'h80000000;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb_[i], tm[i], r, inv, lat);
      tests++;
      if (r !== te[i] || inv !== 1'b0) begin
        fails++;
        $display("FAIL basic[%0d]: result=%h invalid=%b, want %h/0", i, r, inv, te[i]);
      end
      tests++;
      if (lat !== 2) begin
        fails++;
        $display("FAIL basic_latency[%0d]: got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_nan();
    logic [31:0] ta[3], tb_[3], te[3];
    logic        tm[3], ti[3];
    logic [31:0] r;
    logic        inv;
    int          lat;
    ta[0] = 32'h7FC00001; tb_[0] = 32'h3F800000; tm[0] = 1; te[0] = 32'h3F800000; ti[0] = 0;
    ta[1] = 32'h7F800001; tb_[1] = 32'h40400000; tm[1] = 0; te[1] = 32'h40400000; ti[1] = 1;
    ta[2] = 32'h7FC00000; tb_[2] = 32'hFFC12345; tm[2] = 0; te[2] = 32'h7FC00000; ti[2] = 0;
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb_[i], tm[i], r, inv, lat);
      tests++;
      if (r !== te[i] || inv !== ti[i]) begin
        fails++;
        $display("FAIL nan[%0d]: result=%h invalid=%b, want %h/%b", i, r, inv, te[i], ti[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit seen;
    seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; op1 = 32'h3F800000; op2 = 32'h40000000; mode = 1'b1;
    tick();
    op1 = 32'h41000000; op2 = 32'h40000000; mode = 1'b0;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      fails++;
      $display("FAIL midstream_reset: out_valid=%b result=%h, want 0/00000000", out_valid, result);
    end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midstream_in_ready: got %b want 1", in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (out_valid === 1'b1) seen = 1;
      tick();
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midstream_flush: flushed item appeared at output, want none");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a[4], b[4];
    logic        m[4];
    logic [32:0] exp_q[$];
    int idx, nout;
    bit in_fire, out_fire;
    idx = 0; nout = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_op(); b[i] = rand_op(); m[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 40 && nout < 4; c++) begin
      in_valid  = (idx < 4);
      op1 = a[idx % 4]; op2 = b[idx % 4]; mode = m[idx % 4];
      out_ready = (c >= 6);
      #1;
      if (c == 3) begin
        tests++;
        if (in_ready !== 1'b0 || idx != 2) begin
          fails++;
          $display("FAIL bp_in_ready_drop: in_ready=%b accepted=%0d, want 0/2", in_ready, idx);
        end
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        tests++;
        if ({invalid, result} !== exp_q[0]) begin
          fails++;
          $display("FAIL bp_result[%0d] cycle %0d: got %b/%h want %b/%h", nout, c, invalid, result, exp_q[0][32], exp_q[0][31:0]);
        end
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      tick();
      if (in_fire) begin
        exp_q.push_back(model(a[idx], b[idx], m[idx]));
        idx++;
      end
      if (out_fire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        nout++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (nout != 4) begin
      fails++;
      $display("FAIL bp_count: delivered %0d want 4", nout);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a[16], b[16];
    logic        m[16];
    logic [32:0] exp_q[$];
    int idx, nout;
    bit in_fire, out_fire, want_vld;
    idx = 0; nout = 0;
    a[0] = 32'h00000001; b[0] = 32'h80000001; m[0] = 1'b0;
    for (int i = 1; i < 16; i++) begin
      a[i] = rand_op(); b[i] = rand_op(); m[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      in_valid = (idx < 16);
      op1 = a[idx % 16]; op2 = b[idx % 16]; mode = m[idx % 16];
      #1;
      want_vld = (c >= 2 && c < 18);
      tests++;
      if (out_valid !== want_vld) begin
        fails++;
        $display("FAIL b2b_out_valid cycle %0d: got %b want %b", c, out_valid, want_vld);
      end
      if (idx < 16) begin
        tests++;
        if (in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_in_ready cycle %0d: got %b want 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        tests++;
        if ({invalid, result} !== exp_q[0]) begin
          fails++;
          $display("FAIL b2b_result[%0d]: got %b/%h want %b/%h", nout, invalid, result, exp_q[0][32], exp_q[0][31:0]);
        end
      end
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      tick();
      if (in_fire) begin
        exp_q.push_back(model(a[idx], b[idx], m[idx]));
        idx++;
      end
      if (out_fire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        nout++;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (nout != 16) begin
      fails++;
      $display("FAIL b2b_count: delivered %0d want 16", nout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nan();
    test_reset_midstream();
    test_backpressure();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
